// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte master: FSM encoding, mode bit positions
// and the values registers take on reset.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_HALF_A = 3'd2,
        ST_HALF_B = 3'd3,
        ST_DONE   = 3'd4
    } spi_state_t;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    localparam logic [1:0] RST_MODE = 2'b00;
    localparam logic       RST_MOSI = 1'b1;

endpackage

// File: rtl/spi_halfdiv.sv
// SCK half-period timer: reloads from div on load or on reaching zero,
// so each half lasts div+1 enabled cycles.
module spi_halfdiv #(
    parameter int DIVW = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            load,
    input  logic            en,
    input  logic [DIVW-1:0] div,
    output logic            tc
);

    logic [DIVW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= div;
        end else if (en) begin
            cnt <= (cnt == '0) ? div : cnt - DIVW'(1);
        end
    end

    // Terminal count is not gated by en so the caller's next-state logic has no loop.
    assign tc = (cnt == '0);

endmodule

// File: rtl/spi_byte_master.sv
// SPI master: one-word TX holding buffer, DATAW-bit MSB-first shifts in modes 0-3,
// programmable SCK half-period, RX register with sticky overrun flag.
//
// Handshakes: TX_STB is taken only while TX_READY=1 (buffer empty) and the buffer
// frees in LOAD; RX_VALID rises in DONE and falls the cycle after a lone RX_ACK;
// CFG_WE is taken only while BUSY=0.
module spi_byte_master
    import spi_pkg::*;
#(
    parameter int NSS   = 2,
    parameter int DATAW = 8,
    parameter int DIVW  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CFG_WE,
    input  logic [NSS-1:0]   CFG_SSN,
    input  logic [1:0]       CFG_MODE,
    input  logic [DIVW-1:0]  CFG_DIV,
    input  logic             TX_STB,
    input  logic [DATAW-1:0] TX_DATA,
    output logic             TX_READY,
    output logic [DATAW-1:0] RX_DATA,
    output logic             RX_VALID,
    input  logic             RX_ACK,
    output logic             RX_OVR,
    output logic             BUSY,
    output logic             SCK,
    output logic             MOSI,
    input  logic [NSS:0]     MISO,
    output logic [NSS-1:0]   nSS,
    output logic [2:0]       DBG_STATE
);

    localparam int CW = (DATAW > 1) ? $clog2(DATAW) : 1;

    spi_state_t       state, state_n;
    logic [NSS-1:0]   nss_q;
    logic [1:0]       mode_q;
    logic [DIVW-1:0]  div_q;
    logic [DATAW-1:0] tx_buf, shreg, rx_q;
    logic             buf_full, rx_bit, mosi_q, miso_sel;
    logic             rx_valid_q, rx_ovr_q;
    logic [CW-1:0]    bit_cnt;
    logic             div_ld, div_en, div_tc, lead, trail, cfg_acc;
    logic             cpol, cpha;

    assign cpol    = mode_q[CPOL_BIT];
    assign cpha    = mode_q[CPHA_BIT];
    assign cfg_acc = CFG_WE && (state == ST_IDLE);

    spi_halfdiv #(.DIVW(DIVW)) u_halfdiv (
        .CLK  (CLK),
        .RST  (RST),
        .load (div_ld),
        .en   (div_en),
        .div  (div_q),
        .tc   (div_tc)
    );

    // Lowest-numbered asserted select wins; the spare line serves the deselected bus.
    always_comb begin
        miso_sel = MISO[NSS];
        for (int i = NSS - 1; i >= 0; i--) begin
            if (!nss_q[i]) miso_sel = MISO[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        div_ld  = 1'b0;
        div_en  = 1'b0;
        lead    = 1'b0;
        trail   = 1'b0;
        case (state)
            ST_IDLE: if (buf_full) state_n = ST_LOAD;
            ST_LOAD: begin
                div_ld  = 1'b1;
                state_n = ST_HALF_A;
            end
            ST_HALF_A: begin
                div_en = 1'b1;
                if (div_tc) begin
                    lead    = 1'b1;
                    state_n = ST_HALF_B;
                end
            end
            ST_HALF_B: begin
                div_en = 1'b1;
                if (div_tc) begin
                    trail   = 1'b1;
                    state_n = (bit_cnt == CW'(DATAW - 1)) ? ST_DONE : ST_HALF_A;
                end
            end
            ST_DONE: state_n = buf_full ? ST_LOAD : ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            nss_q      <= '1;
            mode_q     <= RST_MODE;
            div_q      <= '1;
            tx_buf     <= '0;
            buf_full   <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            rx_bit     <= 1'b0;
            mosi_q     <= RST_MOSI;
            rx_q       <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            if (cfg_acc) begin
                nss_q  <= CFG_SSN;
                mode_q <= CFG_MODE;
                div_q  <= CFG_DIV;
            end

            if (TX_STB && !buf_full) begin
                tx_buf   <= TX_DATA;
                buf_full <= 1'b1;
            end else if (state == ST_LOAD) begin
                buf_full <= 1'b0;
            end

            if (state == ST_LOAD) begin
                shreg   <= tx_buf;
                bit_cnt <= '0;
                if (!cpha) mosi_q <= tx_buf[DATAW-1];
            end

            // CPHA=0 holds the sampled bit until the trailing edge shifts it in.
            if (lead) begin
                if (cpha) mosi_q <= shreg[DATAW-1];
                else      rx_bit <= miso_sel;
            end

            if (trail) begin
                bit_cnt <= bit_cnt + CW'(1);
                if (cpha) begin
                    shreg <= {shreg[DATAW-2:0], miso_sel};
                end else begin
                    shreg  <= {shreg[DATAW-2:0], rx_bit};
                    mosi_q <= shreg[DATAW-2];
                end
            end

            if (state == ST_DONE) begin
                rx_q       <= shreg;
                rx_valid_q <= 1'b1;
                if (rx_valid_q && !RX_ACK) rx_ovr_q <= 1'b1;
                if (!buf_full) mosi_q <= RST_MOSI;
            end else begin
                if (RX_ACK)  rx_valid_q <= 1'b0;
                if (cfg_acc) rx_ovr_q   <= 1'b0;
            end
        end
    end

    assign TX_READY  = !buf_full;
    assign BUSY      = (state != ST_IDLE);
    assign SCK       = cpol ^ (state == ST_HALF_B);
    assign MOSI      = mosi_q;
    assign nSS       = nss_q;
    assign RX_DATA   = rx_q;
    assign RX_VALID  = rx_valid_q;
    assign RX_OVR    = rx_ovr_q;
    assign DBG_STATE = state;

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: behavioural SPI slaves on every MISO line, a word-level
// expectation queue, and timing measured from SCK/BUSY waveforms.
module tb_spi_byte_master;

    localparam int NSS   = 2;
    localparam int DATAW = 8;
    localparam int DIVW  = 8;

    logic             CLK = 1'b0;
    logic             RST, CFG_WE, TX_STB, RX_ACK;
    logic [NSS-1:0]   CFG_SSN;
    logic [1:0]       CFG_MODE;
    logic [DIVW-1:0]  CFG_DIV;
    logic [DATAW-1:0] TX_DATA, RX_DATA;
    logic             TX_READY, RX_VALID, RX_OVR, BUSY, SCK, MOSI;
    logic [NSS:0]     MISO;
    logic [NSS-1:0]   nSS;
    logic [2:0]       DBG_STATE;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DATAW-1:0] exp_q[$];

    // Slave model: every line shifts its own word; slv_got collects what the master sent.
    logic [DATAW-1:0] slv_word [NSS+1];
    logic [NSS:0]     slv_bits;
    logic [DATAW-1:0] slv_got;
    logic             slv_on = 1'b0, slv_cpol = 1'b0, slv_cpha = 1'b0, loopback = 1'b0;
    int               slv_cnt = 0;

    assign MISO = {slv_bits[NSS:1], loopback ? MOSI : slv_bits[0]};

    spi_byte_master #(.NSS(NSS), .DATAW(DATAW), .DIVW(DIVW)) dut (
        .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_SSN(CFG_SSN), .CFG_MODE(CFG_MODE),
        .CFG_DIV(CFG_DIV), .TX_STB(TX_STB), .TX_DATA(TX_DATA), .TX_READY(TX_READY),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_ACK(RX_ACK), .RX_OVR(RX_OVR),
        .BUSY(BUSY), .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .nSS(nSS), .DBG_STATE(DBG_STATE)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, state=%0d", DBG_STATE);
        $fatal(1, "watchdog");
    end

    always @(SCK) begin
        if (slv_on) begin
            if (SCK !== slv_cpol) begin
                if (slv_cpha) begin
                    if (slv_cnt < DATAW)
                        for (int i = 0; i <= NSS; i++) slv_bits[i] = slv_word[i][DATAW-1-slv_cnt];
                end else begin
                    slv_got = {slv_got[DATAW-2:0], MOSI};
                end
            end else begin
                if (slv_cpha) begin
                    slv_got = {slv_got[DATAW-2:0], MOSI};
                    slv_cnt++;
                end else begin
                    slv_cnt++;
                    if (slv_cnt < DATAW)
                        for (int i = 0; i <= NSS; i++) slv_bits[i] = slv_word[i][DATAW-1-slv_cnt];
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cfg(input logic [NSS-1:0] ssn, input logic [1:0] mode, input int div);
        slv_on = 1'b0;
        @(negedge CLK);
        CFG_WE = 1'b1; CFG_SSN = ssn; CFG_MODE = mode; CFG_DIV = DIVW'(div);
        @(negedge CLK);
        CFG_WE = 1'b0;
    endtask

    task automatic slv_arm(input logic cpol, input logic cpha);
        slv_cpol = cpol; slv_cpha = cpha; slv_cnt = 0; slv_got = '0;
        for (int i = 0; i <= NSS; i++) slv_bits[i] = slv_word[i][DATAW-1];
        slv_on = 1'b1;
    endtask

    task automatic ack_rx(input string tag);
        @(negedge CLK); RX_ACK = 1'b1;
        @(negedge CLK); RX_ACK = 1'b0;
        n_cmp++;
        if (RX_VALID !== 1'b0) begin
            n_bad++; $display("FAIL %s_ack: RX_VALID=%b want 0", tag, RX_VALID);
        end
    endtask

    // Sends one word and measures the whole BUSY window; the expected RX word is
    // taken from the front of exp_q.
    task automatic run_xfer(input logic [DATAW-1:0] tx, input int div, input logic cpol,
                            input logic chk_mosi, input logic poke_cfg, input string tag);
        int len, pulses, run, bad, g;
        logic prev;
        logic [DATAW-1:0] exp;
        @(negedge CLK); TX_STB = 1'b1; TX_DATA = tx;
        @(negedge CLK); TX_STB = 1'b0;
        g = 0;
        while (BUSY !== 1'b1 && g < 8) begin @(negedge CLK); g++; end
        n_cmp++;
        if (BUSY !== 1'b1) begin
            n_bad++; $display("FAIL %s_start: BUSY=%b state=%0d want 1", tag, BUSY, DBG_STATE);
        end
        len = 0; pulses = 0; run = 0; bad = 0; prev = cpol;
        while (BUSY === 1'b1 && len < 5000) begin
            CFG_WE = poke_cfg && (len == 2);
            if (SCK !== cpol) begin
                if (prev === cpol) pulses++;
                run++;
            end else begin
                if (run != 0 && run != div + 1) bad++;
                run = 0;
            end
            prev = SCK;
            len++;
            @(negedge CLK);
        end
        CFG_WE = 1'b0;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~tx;
        n_cmp++;
        if (len != 2 + 2 * DATAW * (div + 1)) begin
            n_bad++; $display("FAIL %s_len: busy %0d cycles want %0d", tag, len, 2 + 2 * DATAW * (div + 1));
        end
        n_cmp++;
        if (pulses != DATAW) begin
            n_bad++; $display("FAIL %s_pulses: %0d SCK pulses want %0d", tag, pulses, DATAW);
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL %s_halfper: %0d active halves not %0d cycles", tag, bad, div + 1);
        end
        n_cmp++;
        if (RX_VALID !== 1'b1 || RX_DATA !== exp) begin
            n_bad++; $display("FAIL %s_rx: RX_DATA=%h VALID=%b want %h/1", tag, RX_DATA, RX_VALID, exp);
        end
        if (chk_mosi) begin
            n_cmp++;
            if (slv_got !== tx) begin
                n_bad++; $display("FAIL %s_mosi: slave got %h want %h", tag, slv_got, tx);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        RST = 1'b1; CFG_WE = 0; TX_STB = 0; RX_ACK = 0; CFG_SSN = '0; CFG_MODE = 0; CFG_DIV = 0; TX_DATA = 0;
        for (int i = 0; i <= NSS; i++) slv_word[i] = '0;
        slv_bits = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (nSS !== '1 || SCK !== 1'b0 || MOSI !== 1'b1) begin
            n_bad++; $display("FAIL reset_pins: nSS=%b SCK=%b MOSI=%b want 11/0/1", nSS, SCK, MOSI);
        end
        n_cmp++;
        if (TX_READY !== 1'b1 || BUSY !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags: TX_READY=%b BUSY=%b want 1/0", TX_READY, BUSY);
        end
        n_cmp++;
        if (RX_VALID !== 1'b0 || RX_DATA !== '0 || RX_OVR !== 1'b0) begin
            n_bad++; $display("FAIL reset_rx: VALID=%b DATA=%h OVR=%b want 0/00/0", RX_VALID, RX_DATA, RX_OVR);
        end
    endtask

    task automatic test_mode0_loop;
        cfg(2'b10, 2'd0, 0);
        loopback = 1'b1;
        n_cmp++;
        if (nSS !== 2'b10 || SCK !== 1'b0) begin
            n_bad++; $display("FAIL m0_cfg: nSS=%b SCK=%b want 10/0", nSS, SCK);
        end
        slv_arm(1'b0, 1'b0);
        exp_q.push_back(8'hA5);
        run_xfer(8'hA5, 0, 1'b0, 1'b1, 1'b0, "m0");
        n_cmp++;
        if (MOSI !== 1'b1) begin
            n_bad++; $display("FAIL m0_idle_mosi: MOSI=%b want 1", MOSI);
        end
        ack_rx("m0");
    endtask

    task automatic test_mode3;
        cfg(2'b10, 2'd3, 2);
        loopback = 1'b0;
        n_cmp++;
        if (SCK !== 1'b1) begin
            n_bad++; $display("FAIL m3_idle_sck: SCK=%b want 1", SCK);
        end
        slv_word[0] = 8'hC3; slv_word[1] = 8'h00; slv_word[2] = 8'h00;
        slv_arm(1'b1, 1'b1);
        exp_q.push_back(8'hC3);
        run_xfer(8'h3C, 2, 1'b1, 1'b1, 1'b0, "m3");
        ack_rx("m3");
    endtask

    task automatic test_random;
        logic [NSS-1:0] ssn;
        logic [1:0] mode;
        logic [DATAW-1:0] tx;
        int div, sel;
        loopback = 1'b0;
        for (int t = 0; t < 8; t++) begin
            mode = 2'($urandom_range(0, 3));
            div  = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0:       ssn = 2'b10;
                1:       ssn = 2'b01;
                default: ssn = 2'b11;
            endcase
            cfg(ssn, mode, div);
            for (int i = 0; i <= NSS; i++) slv_word[i] = DATAW'($urandom);
            tx = DATAW'($urandom);
            sel = NSS;
            for (int i = 0; i < NSS; i++) if (!ssn[i]) begin sel = i; break; end
            exp_q.push_back(slv_word[sel]);
            slv_arm(mode[1], mode[0]);
            run_xfer(tx, div, mode[1], 1'b1, 1'b0, $sformatf("rnd%0d", t));
            ack_rx($sformatf("rnd%0d", t));
        end
    endtask

    task automatic test_back_to_back;
        int len;
        logic rdy_mid, rdy_full, rdy_after;
        logic [DATAW-1:0] exp;
        cfg(2'b10, 2'd0, 0);
        loopback = 1'b1;
        exp_q.delete();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        @(negedge CLK); TX_STB = 1'b1; TX_DATA = 8'h11;
        @(negedge CLK); TX_STB = 1'b0;
        n_cmp++;
        if (TX_READY !== 1'b0) begin
            n_bad++; $display("FAIL b2b_fill: TX_READY=%b want 0", TX_READY);
        end
        len = 0;
        while (BUSY !== 1'b1 && len < 8) begin @(negedge CLK); len++; end
        len = 0; rdy_mid = 1'b0; rdy_full = 1'b1; rdy_after = 1'b0;
        while (BUSY === 1'b1 && len < 500) begin
            if (len == 1) begin
                rdy_mid = TX_READY; TX_STB = 1'b1; TX_DATA = 8'h22;
            end else begin
                TX_STB = 1'b0;
            end
            if (len == 3)  rdy_full  = TX_READY;
            if (len == 19) rdy_after = TX_READY;
            len++;
            @(negedge CLK);
        end
        TX_STB = 1'b0;
        n_cmp++;
        if (rdy_mid !== 1'b1 || rdy_full !== 1'b0 || rdy_after !== 1'b1) begin
            n_bad++; $display("FAIL b2b_ready: after LOAD1=%b after STB2=%b after LOAD2=%b want 1/0/1",
                              rdy_mid, rdy_full, rdy_after);
        end
        n_cmp++;
        if (len != 2 * (2 + 2 * DATAW)) begin
            n_bad++; $display("FAIL b2b_len: continuous busy %0d cycles want %0d", len, 2 * (2 + 2 * DATAW));
        end
        exp = exp_q[$];
        n_cmp++;
        if (RX_DATA !== exp || RX_VALID !== 1'b1 || RX_OVR !== (exp_q.size() > 1)) begin
            n_bad++; $display("FAIL b2b_ovr: DATA=%h VALID=%b OVR=%b want %h/1/1", RX_DATA, RX_VALID, RX_OVR, exp);
        end
        exp_q.delete();
        cfg(2'b10, 2'd0, 0);
        n_cmp++;
        if (RX_OVR !== 1'b0 || RX_VALID !== 1'b1) begin
            n_bad++; $display("FAIL ovr_clear: OVR=%b VALID=%b want 0/1", RX_OVR, RX_VALID);
        end
        // RX_ACK lands in the same cycle the next word is stored: no overrun.
        @(negedge CLK); TX_STB = 1'b1; TX_DATA = 8'h5A;
        @(negedge CLK); TX_STB = 1'b0;
        len = 0;
        while (BUSY !== 1'b1 && len < 8) begin @(negedge CLK); len++; end
        len = 0;
        while (BUSY === 1'b1 && len < 500) begin
            RX_ACK = (len == 2 * DATAW + 1);
            len++;
            @(negedge CLK);
        end
        RX_ACK = 1'b0;
        n_cmp++;
        if (RX_DATA !== 8'h5A || RX_VALID !== 1'b1 || RX_OVR !== 1'b0) begin
            n_bad++; $display("FAIL ack_same: DATA=%h VALID=%b OVR=%b want 5a/1/0", RX_DATA, RX_VALID, RX_OVR);
        end
        ack_rx("ack_same");
    endtask

    task automatic test_abort;
        int len, pulses;
        logic prev;
        cfg(2'b01, 2'd2, 1);
        loopback = 1'b1;
        @(negedge CLK); TX_STB = 1'b1; TX_DATA = 8'hF0;
        @(negedge CLK); TX_STB = 1'b0;
        len = 0;
        while (BUSY !== 1'b1 && len < 8) begin @(negedge CLK); len++; end
        len = 0; pulses = 0; prev = 1'b1;
        while (BUSY === 1'b1 && pulses < 4 && len < 500) begin
            TX_STB = (len == 1);
            TX_DATA = 8'h0F;
            @(negedge CLK);
            len++;
            if (SCK === 1'b0 && prev === 1'b1) pulses++;
            prev = SCK;
        end
        TX_STB = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_cmp++;
        if (pulses != 4 || SCK !== 1'b0 || MOSI !== 1'b1 || nSS !== '1) begin
            n_bad++; $display("FAIL abort_pins: pulses=%0d SCK=%b MOSI=%b nSS=%b want 4/0/1/11", pulses, SCK, MOSI, nSS);
        end
        n_cmp++;
        if (BUSY !== 1'b0 || TX_READY !== 1'b1 || RX_VALID !== 1'b0) begin
            n_bad++; $display("FAIL abort_flags: BUSY=%b TX_READY=%b VALID=%b want 0/1/0", BUSY, TX_READY, RX_VALID);
        end
        repeat (4) @(negedge CLK);
        n_cmp++;
        if (BUSY !== 1'b0) begin
            n_bad++; $display("FAIL abort_quiet: BUSY=%b want 0 (buffer discarded)", BUSY);
        end
        exp_q.delete();
    endtask

    task automatic test_deselect;
        cfg(2'b11, 2'd0, 1);
        loopback = 1'b0;
        slv_word[0] = 8'h00; slv_word[1] = 8'h00; slv_word[2] = 8'hFF;
        slv_arm(1'b0, 1'b0);
        CFG_SSN = 2'b10; CFG_MODE = 2'd3; CFG_DIV = '0;
        exp_q.push_back(8'hFF);
        run_xfer(8'h00, 1, 1'b0, 1'b1, 1'b1, "desel");
        n_cmp++;
        if (nSS !== 2'b11 || SCK !== 1'b0) begin
            n_bad++; $display("FAIL desel_cfg_busy: nSS=%b SCK=%b want 11/0", nSS, SCK);
        end
        ack_rx("desel");
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_mode0_loop();
        test_mode3();
        test_random();
        test_back_to_back();
        test_abort();
        test_deselect();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
